// File: rtl/rename_reg_file.sv
// Purpose : architectural register file with per-register rename tags (ROB dependency table).
// Latency : reads are combinational (zero cycles); issue/commit/flush take effect on the next clk_in edge.
// Backpressure: rdy_in low freezes every register, tag and snapshot; read outputs stay live.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global ready), clear_in (pipeline flush)
//   rd_id_in / rd_val_out / rd_dep_out / rd_has_dep_out : NUM_RD flattened read ports, port k in slice k
//   iss_valid_in / iss_rd_in / iss_rob_in               : destination rename at issue
//   cmt_valid_in / cmt_rd_in / cmt_val_in / cmt_rob_in  : ROB commit write
//   ckpt_take_in / ckpt_restore_in / ckpt_valid_out     : single dep-table snapshot (RF_CKPT_EN only)
//
// Build option: define RF_CKPT_EN to add the branch-recovery snapshot of the dep table.

`ifndef ROB_INDEX_BIT
`define ROB_INDEX_BIT 4
`endif

module rename_reg_file #(
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = `ROB_INDEX_BIT,
    parameter int NUM_RD    = 3
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        clear_in,
    input  logic [NUM_RD*5-1:0]         rd_id_in,
    output logic [NUM_RD*DATA_W-1:0]    rd_val_out,
    output logic [NUM_RD*ROB_IDX_W-1:0] rd_dep_out,
    output logic [NUM_RD-1:0]           rd_has_dep_out,
    input  logic                        iss_valid_in,
    input  logic [4:0]                  iss_rd_in,
    input  logic [ROB_IDX_W-1:0]        iss_rob_in,
    input  logic                        cmt_valid_in,
    input  logic [4:0]                  cmt_rd_in,
    input  logic [DATA_W-1:0]           cmt_val_in,
    input  logic [ROB_IDX_W-1:0]        cmt_rob_in
`ifdef RF_CKPT_EN
    ,
    input  logic                        ckpt_take_in,
    input  logic                        ckpt_restore_in,
    output logic                        ckpt_valid_out
`endif
);

    localparam int NREG = 32;

    // Architectural state. Entry 0 is never written and stays zero.
    logic [DATA_W-1:0]    val_q [NREG];
    logic [ROB_IDX_W-1:0] dep_q [NREG];
    logic [NREG-1:0]      has_q;

    // Per-register decode of this cycle's issue and commit.
    logic [NREG-1:0]      cmt_hit;
    logic [NREG-1:0]      iss_hit;

    // Dep table after issue/commit only (no flush/restore); also what a snapshot captures.
    logic [ROB_IDX_W-1:0] dep_nom [NREG];
    logic [NREG-1:0]      has_nom;

    // Final next-state dep table.
    logic [ROB_IDX_W-1:0] dep_nxt [NREG];
    logic [NREG-1:0]      has_nxt;

`ifdef RF_CKPT_EN
    logic [ROB_IDX_W-1:0] snap_dep_q [NREG];
    logic [NREG-1:0]      snap_has_q;
    logic                 ckpt_valid_q;
    // Snapshot with this cycle's commit already retired from it.
    logic [ROB_IDX_W-1:0] snap_dep_cmt [NREG];
    logic [NREG-1:0]      snap_has_cmt;

    assign ckpt_valid_out = ckpt_valid_q;
`endif

    // ------------------------------------------------------------------
    // Issue / commit effect on the dep table
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cmt_hit[i] = cmt_valid_in && (cmt_rd_in == i[4:0]) && (i != 0);
            iss_hit[i] = iss_valid_in && (iss_rd_in == i[4:0]) && (i != 0);
            has_nom[i] = has_q[i];
            dep_nom[i] = dep_q[i];
            // Commit only retires the tag it owns; a younger rename stays.
            if (cmt_hit[i] && has_q[i] && (dep_q[i] == cmt_rob_in)) begin
                has_nom[i] = 1'b0;
                dep_nom[i] = '0;
            end
            // A same-cycle issue to the same register always wins over commit.
            if (iss_hit[i]) begin
                has_nom[i] = 1'b1;
                dep_nom[i] = iss_rob_in;
            end
        end
    end

`ifdef RF_CKPT_EN
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            snap_has_cmt[i] = snap_has_q[i];
            snap_dep_cmt[i] = snap_dep_q[i];
            if (cmt_hit[i] && snap_has_q[i] && (snap_dep_q[i] == cmt_rob_in)) begin
                snap_has_cmt[i] = 1'b0;
                snap_dep_cmt[i] = '0;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Flush / restore selection: clear > restore > normal operation
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            has_nxt[i] = has_nom[i];
            dep_nxt[i] = dep_nom[i];
            if (clear_in) begin
                has_nxt[i] = 1'b0;
                dep_nxt[i] = '0;
            end
`ifdef RF_CKPT_EN
            else if (ckpt_restore_in) begin
                // Restore without a live snapshot degenerates to a flush.
                // Same-cycle issue is dropped in both cases.
                has_nxt[i] = ckpt_valid_q ? snap_has_cmt[i] : 1'b0;
                dep_nxt[i] = ckpt_valid_q ? snap_dep_cmt[i] : '0;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                dep_q[i] <= '0;
            end
            has_q <= '0;
        end else if (rdy_in) begin
            // Value write happens even during a flush.
            for (int i = 1; i < NREG; i++) begin
                if (cmt_hit[i]) begin
                    val_q[i] <= cmt_val_in;
                end
            end
            for (int i = 1; i < NREG; i++) begin
                dep_q[i] <= dep_nxt[i];
            end
            has_q <= {has_nxt[NREG-1:1], 1'b0};
        end
    end

`ifdef RF_CKPT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                snap_dep_q[i] <= '0;
            end
            snap_has_q   <= '0;
            ckpt_valid_q <= 1'b0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int i = 1; i < NREG; i++) begin
                    snap_dep_q[i] <= snap_dep_cmt[i];
                end
                snap_has_q   <= {snap_has_cmt[NREG-1:1], 1'b0};
                ckpt_valid_q <= 1'b0;
            end else if (ckpt_restore_in) begin
                for (int i = 1; i < NREG; i++) begin
                    snap_dep_q[i] <= snap_dep_cmt[i];
                end
                snap_has_q   <= {snap_has_cmt[NREG-1:1], 1'b0};
                ckpt_valid_q <= 1'b0;
            end else if (ckpt_take_in) begin
                // Capture the table as it will look after this edge.
                for (int i = 1; i < NREG; i++) begin
                    snap_dep_q[i] <= dep_nom[i];
                end
                snap_has_q   <= {has_nom[NREG-1:1], 1'b0};
                ckpt_valid_q <= 1'b1;
            end else begin
                for (int i = 1; i < NREG; i++) begin
                    snap_dep_q[i] <= snap_dep_cmt[i];
                end
                snap_has_q   <= {snap_has_cmt[NREG-1:1], 1'b0};
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read ports: combinational, see pre-rename state plus commit bypass
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [4:0]           id;
        logic [DATA_W-1:0]    pv;
        logic [ROB_IDX_W-1:0] pd;
        logic                 ph;

        assign id = rd_id_in[k*5 +: 5];

        always_comb begin
            pv = val_q[id];
            pd = dep_q[id];
            ph = has_q[id];
            if (id == 5'd0) begin
                pv = '0;
                pd = '0;
                ph = 1'b0;
            end else if (cmt_valid_in && (cmt_rd_in == id)) begin
                pv = cmt_val_in;
                // The committing tag is retired; a younger tag is still pending.
                if (has_q[id] && (dep_q[id] == cmt_rob_in)) begin
                    pd = '0;
                    ph = 1'b0;
                end
            end
        end

        assign rd_val_out[k*DATA_W +: DATA_W]       = pv;
        assign rd_dep_out[k*ROB_IDX_W +: ROB_IDX_W] = pd;
        assign rd_has_dep_out[k]                    = ph;
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Purpose : self-checking bench for rename_reg_file (directed cases plus random traffic vs a reference model).
// Latency : model checks reads combinationally each cycle, then advances on the clock edge.
// Backpressure: rdy_in is randomly dropped; the model freezes with it.
module tb_rename_reg_file;

    localparam int DW = 32;
    localparam int RW = 4;
    localparam int NR = 3;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic              rst_in, rdy_in, clear_in;
    logic [NR*5-1:0]   rd_id_in;
    logic [NR*DW-1:0]  rd_val_out;
    logic [NR*RW-1:0]  rd_dep_out;
    logic [NR-1:0]     rd_has_dep_out;
    logic              iss_valid_in, cmt_valid_in;
    logic [4:0]        iss_rd_in, cmt_rd_in;
    logic [RW-1:0]     iss_rob_in, cmt_rob_in;
    logic [DW-1:0]     cmt_val_in;
`ifdef RF_CKPT_EN
    logic              ckpt_take_in, ckpt_restore_in, ckpt_valid_out;
`endif

    rename_reg_file #(.DATA_W(DW), .ROB_IDX_W(RW), .NUM_RD(NR)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .rd_id_in(rd_id_in), .rd_val_out(rd_val_out), .rd_dep_out(rd_dep_out),
        .rd_has_dep_out(rd_has_dep_out),
        .iss_valid_in(iss_valid_in), .iss_rd_in(iss_rd_in), .iss_rob_in(iss_rob_in),
        .cmt_valid_in(cmt_valid_in), .cmt_rd_in(cmt_rd_in), .cmt_val_in(cmt_val_in),
        .cmt_rob_in(cmt_rob_in)
`ifdef RF_CKPT_EN
        , .ckpt_take_in(ckpt_take_in), .ckpt_restore_in(ckpt_restore_in),
        .ckpt_valid_out(ckpt_valid_out)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: architectural value, pending flag and tag per register.
    logic [DW-1:0] m_val [32];
    logic          m_has [32];
    logic [RW-1:0] m_dep [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int r = 0; r < 32; r++) begin
            m_val[r] = '0; m_has[r] = 1'b0; m_dep[r] = '0;
        end
    endtask

    task automatic set_rd(input int a, input int b, input int c);
        rd_id_in[4:0]   = 5'(a);
        rd_id_in[9:5]   = 5'(b);
        rd_id_in[14:10] = 5'(c);
    endtask

    task automatic idle();
        rdy_in = 1'b1; clear_in = 1'b0;
        iss_valid_in = 1'b0; iss_rd_in = '0; iss_rob_in = '0;
        cmt_valid_in = 1'b0; cmt_rd_in = '0; cmt_rob_in = '0; cmt_val_in = '0;
`ifdef RF_CKPT_EN
        ckpt_take_in = 1'b0; ckpt_restore_in = 1'b0;
`endif
    endtask

    // Compare every read port against what the model says a reader should see now.
    task automatic check_ports();
        for (int k = 0; k < NR; k++) begin
            int            id;
            logic [DW-1:0] ev;
            logic          eh;
            logic [RW-1:0] ed;
            id = int'(rd_id_in[k*5 +: 5]);
            if (id == 0) begin
                ev = '0; eh = 1'b0; ed = '0;
            end else begin
                ev = m_val[id]; eh = m_has[id]; ed = m_dep[id];
                if (cmt_valid_in && int'(cmt_rd_in) == id) begin
                    ev = cmt_val_in;
                    if (eh && ed == cmt_rob_in) begin eh = 1'b0; ed = '0; end
                end
            end
            chk($sformatf("val p%0d x%0d", k, id), 64'(rd_val_out[k*DW +: DW]), 64'(ev));
            chk($sformatf("has p%0d x%0d", k, id), 64'(rd_has_dep_out[k]), 64'(eh));
            chk($sformatf("dep p%0d x%0d", k, id), 64'(rd_dep_out[k*RW +: RW]), 64'(ed));
        end
    endtask

    // Apply the architectural update rules for one clock edge.
    task automatic model_edge();
        logic [DW-1:0] nv [32];
        logic          nh [32];
        logic [RW-1:0] nd [32];
        if (!rdy_in) return;
        for (int r = 0; r < 32; r++) begin
            nv[r] = m_val[r]; nh[r] = m_has[r]; nd[r] = m_dep[r];
            if (r != 0) begin
                if (cmt_valid_in && int'(cmt_rd_in) == r) nv[r] = cmt_val_in;
                if (clear_in) begin
                    nh[r] = 1'b0; nd[r] = '0;
                end else if (iss_valid_in && int'(iss_rd_in) == r) begin
                    nh[r] = 1'b1; nd[r] = iss_rob_in;
                end else if (cmt_valid_in && int'(cmt_rd_in) == r && m_has[r] && m_dep[r] == cmt_rob_in) begin
                    nh[r] = 1'b0; nd[r] = '0;
                end
            end
        end
        for (int r = 0; r < 32; r++) begin
            m_val[r] = nv[r]; m_has[r] = nh[r]; m_dep[r] = nd[r];
        end
    endtask

    task automatic tick();
        #1;
        check_ports();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        mreset();
        idle();
        set_rd(1, 2, 3);
        rst_in = 1'b0;
        #3;
        check_ports();
        chk("reset val", 64'(rd_val_out), 64'(0));
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        set_rd(5, 9, 0);
        tick();

        // Issue x5 tag 3, then commit it with the same tag.
        iss_valid_in = 1'b1; iss_rd_in = 5'd5; iss_rob_in = 4'd3;
        set_rd(5, 5, 4);
        tick();
        idle();
        #1;
        chk("r031 has", 64'(rd_has_dep_out[0]), 64'(1));
        chk("r031 dep", 64'(rd_dep_out[3:0]), 64'(3));
        cmt_valid_in = 1'b1; cmt_rd_in = 5'd5; cmt_rob_in = 4'd3; cmt_val_in = 32'h1234;
        #1;
        chk("r031 byp val", 64'(rd_val_out[31:0]), 64'h1234);
        chk("r031 byp has", 64'(rd_has_dep_out[0]), 64'(0));
        tick();
        idle();
        #1;
        chk("r031 st val", 64'(rd_val_out[31:0]), 64'h1234);
        chk("r031 st has", 64'(rd_has_dep_out[0]), 64'(0));

        // Same-cycle issue x7 tag 4 and commit of the older tag 2.
        iss_valid_in = 1'b1; iss_rd_in = 5'd7; iss_rob_in = 4'd2;
        set_rd(7, 7, 7);
        tick();
        idle();
        iss_valid_in = 1'b1; iss_rd_in = 5'd7; iss_rob_in = 4'd4;
        cmt_valid_in = 1'b1; cmt_rd_in = 5'd7; cmt_rob_in = 4'd2; cmt_val_in = 32'hAA;
        tick();
        idle();
        #1;
        chk("r032 val", 64'(rd_val_out[31:0]), 64'hAA);
        chk("r032 has", 64'(rd_has_dep_out[0]), 64'(1));
        chk("r032 dep", 64'(rd_dep_out[3:0]), 64'(4));

        // Commit with a stale tag keeps the newer dependency.
        iss_valid_in = 1'b1; iss_rd_in = 5'd9; iss_rob_in = 4'd6;
        set_rd(9, 9, 9);
        tick();
        idle();
        cmt_valid_in = 1'b1; cmt_rd_in = 5'd9; cmt_rob_in = 4'd1; cmt_val_in = 32'h55;
        tick();
        idle();
        #1;
        chk("r033 val", 64'(rd_val_out[31:0]), 64'h55);
        chk("r033 has", 64'(rd_has_dep_out[0]), 64'(1));
        chk("r033 dep", 64'(rd_dep_out[3:0]), 64'(6));

        // Register 0 ignores rename and write.
        iss_valid_in = 1'b1; iss_rd_in = 5'd0; iss_rob_in = 4'd3;
        cmt_valid_in = 1'b1; cmt_rd_in = 5'd0; cmt_rob_in = 4'd3; cmt_val_in = 32'hFFFF;
        set_rd(0, 0, 0);
        #1;
        chk("r034 byp all", {28'd0, rd_val_out[31:0], rd_has_dep_out, rd_dep_out[3:0]}, 64'(0));
        tick();
        idle();
        #1;
        chk("r034 vals", 64'(rd_val_out), 64'(0));
        chk("r034 deps", 64'({rd_dep_out, rd_has_dep_out}), 64'(0));

        // Random traffic on a small register/tag range to force collisions.
        for (int n = 0; n < 600; n++) begin
            rdy_in       = ($urandom_range(7) != 0);
            clear_in     = ($urandom_range(15) == 0);
            iss_valid_in = 1'($urandom_range(1));
            iss_rd_in    = 5'($urandom_range(7));
            iss_rob_in   = 4'($urandom_range(3));
            cmt_valid_in = 1'($urandom_range(1));
            cmt_rd_in    = 5'($urandom_range(7));
            cmt_rob_in   = ($urandom_range(1) != 0) ? m_dep[cmt_rd_in] : 4'($urandom_range(3));
            cmt_val_in   = $urandom;
            set_rd(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(7)));
            tick();
        end
        idle();

`ifdef RF_CKPT_EN
        // Snapshot, speculate, retire the snapshot's tag, then restore.
        iss_valid_in = 1'b1; iss_rd_in = 5'd3; iss_rob_in = 4'd2;
        set_rd(3, 3, 3);
        tick();
        idle();
        ckpt_take_in = 1'b1;
        tick();
        idle();
        #1;
        chk("r035 ckpt valid", 64'(ckpt_valid_out), 64'(1));
        iss_valid_in = 1'b1; iss_rd_in = 5'd3; iss_rob_in = 4'd5;
        tick();
        idle();
        cmt_valid_in = 1'b1; cmt_rd_in = 5'd3; cmt_rob_in = 4'd2; cmt_val_in = 32'h9;
        tick();
        idle();
        ckpt_restore_in = 1'b1;
        @(posedge clk_in);
        #1;
        idle();
        #1;
        chk("r035 has", 64'(rd_has_dep_out[0]), 64'(0));
        chk("r035 ckpt valid", 64'(ckpt_valid_out), 64'(0));
        rst_in = 1'b0;
        #1;
        mreset();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
`endif

        // Asynchronous reset mid-cycle while frozen.
        iss_valid_in = 1'b1; iss_rd_in = 5'd4; iss_rob_in = 4'd2;
        cmt_valid_in = 1'b1; cmt_rd_in = 5'd6; cmt_rob_in = 4'd1; cmt_val_in = 32'hBEEF;
        set_rd(4, 6, 7);
        tick();
        idle();
        rdy_in = 1'b0;
        #1;
        chk("r036 pre has", 64'(rd_has_dep_out[0]), 64'(1));
        #2;
        rst_in = 1'b0;
        #1;
        chk("r036 val", 64'(rd_val_out), 64'(0));
        chk("r036 dep", 64'(rd_dep_out), 64'(0));
        chk("r036 has", 64'(rd_has_dep_out), 64'(0));
        mreset();
        @(negedge clk_in);
        rst_in = 1'b1;
        rdy_in = 1'b1;
        @(posedge clk_in);
        #1;
        tick();
        chk("r024 vals", 64'(rd_val_out), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
